// File: rtl/apb_arb_pkg.sv
// Shared encodings for the APB round-robin arbiter: FSM state codes and a
// helper that sizes the ACCESS wait counter from the timeout limit.
package apb_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // A disabled timeout still keeps a 1-bit counter so the datapath stays legal.
  function automatic int cnt_bits(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i,
// wrapping from NUM_REQ-1 back to 0; one-hot result, zero when idle.
module apb_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ requesters onto one APB master port,
// with an optional ACCESS-phase timeout that aborts a stalled transfer.
//
//   state     | meaning
//   ST_IDLE   | waiting for a request; req_ready_o carries the grant
//   ST_SETUP  | APB setup phase, psel_o high, penable_o low
//   ST_ACCESS | APB access phase, waiting for pready_i or the timeout
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 255
) (
  input  logic                                pclk_i,
  input  logic                                prstn_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0]                  req_write_i,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  output logic [APB_DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                                rsp_err_o,
  output logic                                psel_o,
  output logic                                penable_o,
  output logic                                pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]           paddr_o,
  output logic [APB_DATA_WIDTH-1:0]           pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]           prdata_i,
  input  logic                                pready_i,
  input  logic                                pslverr_i,
  output logic                                timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_bits(TIMEOUT);
  localparam logic             TO_EN  = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  arb_state_t                state_q, state_d;
  logic [IDX_W-1:0]          ptr_q, ptr_d;
  logic [IDX_W-1:0]          gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      timeout_q, timeout_d;

  logic [NUM_REQ-1:0]        grant;
  logic [IDX_W-1:0]          gnt_idx;
  logic [APB_ADDR_WIDTH-1:0] sel_addr;
  logic [APB_DATA_WIDTH-1:0] sel_wdata;
  logic                      sel_write;
  logic [NUM_REQ-1:0]        gnt_onehot_q;
  logic                      to_hit;

  apb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign req_ready_o = (state_q == ST_IDLE) ? grant : '0;

  always_comb begin
    gnt_idx   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        gnt_idx   = IDX_W'(k);
        sel_addr  = req_addr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        sel_wdata = req_wdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        sel_write = req_write_i[k];
      end
    end
  end

  always_comb begin
    gnt_onehot_q = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      gnt_onehot_q[k] = (gnt_idx_q == IDX_W'(k));
    end
  end

  assign to_hit = TO_EN && (cnt_q == TO_VAL);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          paddr_d   = sel_addr;
          pwdata_d  = sel_wdata;
          pwrite_d  = sel_write;
          gnt_idx_d = gnt_idx;
          cnt_d     = '0;
          ptr_d     = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // pready_i wins over a timeout landing on the same edge
        if (pready_i) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = gnt_onehot_q;
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
          rsp_err_d   = pslverr_i;
        end else if (to_hit) begin
          state_d     = ST_IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = gnt_onehot_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          timeout_d   = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk_i or negedge prstn_i) begin
    if (!prstn_i) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: directed scenarios plus randomized
// transfers checked against a transaction-level round-robin/timeout model.
module tb_apb_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 5;

  logic            pclk_i = 1'b0;
  logic            prstn_i;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_write_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N*DW-1:0] req_wdata_i;
  logic [N-1:0]    req_ready_o;
  logic [N-1:0]    rsp_valid_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic            rsp_err_o;
  logic            psel_o, penable_o, pwrite_o;
  logic [AW-1:0]   paddr_o;
  logic [DW-1:0]   pwdata_o;
  logic [DW-1:0]   prdata_i;
  logic            pready_i;
  logic            pslverr_i;
  logic            timeout_o;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0] a_addr  [N];
  logic [DW-1:0] a_wdata [N];
  logic          a_write [N];
  int            last_grant;

  apb_rr_arbiter #(
    .NUM_REQ        (N),
    .APB_ADDR_WIDTH (AW),
    .APB_DATA_WIDTH (DW),
    .TIMEOUT        (TO)
  ) dut (
    .pclk_i      (pclk_i),
    .prstn_i     (prstn_i),
    .req_valid_i (req_valid_i),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_ready_o (req_ready_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i),
    .timeout_o   (timeout_o)
  );

  always #5 pclk_i = ~pclk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference round-robin: first valid requester after the last one granted.
  function automatic int rr_pick(input logic [N-1:0] v);
    for (int i = 1; i <= N; i++) begin
      if (v[(last_grant + i) % N]) return (last_grant + i) % N;
    end
    return -1;
  endfunction

  task automatic push_fields();
    for (int k = 0; k < N; k++) begin
      req_addr_i[k*AW +: AW]  = a_addr[k];
      req_wdata_i[k*DW +: DW] = a_wdata[k];
      req_write_i[k]          = a_write[k];
    end
  endtask

  task automatic randomize_fields();
    for (int k = 0; k < N; k++) begin
      a_addr[k]  = $urandom;
      a_wdata[k] = $urandom;
      a_write[k] = 1'($urandom_range(0, 1));
    end
    push_fields();
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the response.
  task automatic do_xfer(input logic [N-1:0] mask, input int waits,
                         input logic slverr, input logic [DW-1:0] rd_val);
    int   g, n_low;
    logic done, aborted;
    logic [DW-1:0] exp_rdata;
    logic exp_err;
    req_valid_i = mask;
    #1;
    g = rr_pick(mask);
    chk("grant", req_ready_o, 64'd1 << g);
    @(posedge pclk_i);
    @(negedge pclk_i);
    chk("setup_psel", {psel_o, penable_o}, 2'b10);
    chk("setup_ready", req_ready_o, 0);
    chk("setup_addr", paddr_o, a_addr[g]);
    chk("setup_wdata", pwdata_o, a_wdata[g]);
    chk("setup_write", pwrite_o, a_write[g]);
    @(posedge pclk_i);
    @(negedge pclk_i);
    chk("access_psel", {psel_o, penable_o}, 2'b11);
    n_low = 0; done = 1'b0; aborted = 1'b0;
    exp_rdata = '0; exp_err = 1'b0;
    while (!done) begin
      pready_i  = (n_low >= waits);
      prdata_i  = pready_i ? rd_val : $urandom;
      pslverr_i = pready_i ? slverr : 1'($urandom_range(0, 1));
      @(posedge pclk_i);
      if (pready_i) begin
        done      = 1'b1;
        exp_rdata = a_write[g] ? '0 : rd_val;
        exp_err   = slverr;
      end else if (n_low == TO) begin
        done      = 1'b1;
        aborted   = 1'b1;
        exp_rdata = '0;
        exp_err   = 1'b1;
      end else begin
        n_low++;
      end
      @(negedge pclk_i);
      if (!done) begin
        chk("wait_psel", {psel_o, penable_o}, 2'b11);
        chk("wait_stable", {pwrite_o, paddr_o, pwdata_o}, {a_write[g], a_addr[g], a_wdata[g]});
        chk("wait_rsp", {rsp_valid_o, timeout_o}, 0);
      end
    end
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    chk("rsp_valid", rsp_valid_o, 64'd1 << g);
    chk("rsp_rdata", rsp_rdata_o, exp_rdata);
    chk("rsp_err", rsp_err_o, exp_err);
    chk("timeout", timeout_o, aborted);
    chk("rsp_idle", {psel_o, penable_o}, 2'b00);
    last_grant = g;
  endtask

  initial begin
    prstn_i     = 1'b0;
    req_valid_i = '0;
    req_write_i = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    prdata_i    = '0;
    pready_i    = 1'b0;
    pslverr_i   = 1'b0;
    last_grant  = N - 1;
    repeat (3) @(negedge pclk_i);
    chk("reset_apb", {psel_o, penable_o, pwrite_o, paddr_o, pwdata_o}, 0);
    chk("reset_rsp", {rsp_valid_o, rsp_rdata_o, rsp_err_o, timeout_o}, 0);
    prstn_i = 1'b1;
    @(negedge pclk_i);
    @(negedge pclk_i);
    chk("idle_no_req", {req_ready_o, psel_o}, 0);

    // Single read from requester 0.
    randomize_fields();
    a_addr[0] = 32'h0000_1004; a_write[0] = 1'b0;
    push_fields();
    do_xfer(4'b0001, 0, 1'b0, 32'hDEAD_BEEF);
    req_valid_i = '0;
    @(negedge pclk_i);

    // Fairness: everyone holds valid, back-to-back transfers.
    randomize_fields();
    for (int i = 0; i < 8; i++) do_xfer(4'b1111, 0, 1'b0, $urandom);
    req_valid_i = '0;
    @(negedge pclk_i);

    // Write with wait states.
    a_addr[1] = 32'h0000_2000; a_wdata[1] = 32'h1234_5678; a_write[1] = 1'b1;
    push_fields();
    do_xfer(4'b0010, 5, 1'b0, $urandom);

    // Timeout abort, then a normal transfer straight after.
    do_xfer(4'b0100, 20, 1'b0, $urandom);
    do_xfer(4'b1000, 0, 1'b0, $urandom);

    // Slave error.
    do_xfer(4'b0001, 0, 1'b1, $urandom);
    req_valid_i = '0;
    @(negedge pclk_i);

    // Reset while in ACCESS.
    randomize_fields();
    req_valid_i = 4'b0100;
    @(posedge pclk_i);
    @(posedge pclk_i);
    @(negedge pclk_i);
    chk("pre_reset_access", {psel_o, penable_o}, 2'b11);
    prstn_i     = 1'b0;
    req_valid_i = '0;
    #1;
    chk("mid_reset_apb", {psel_o, penable_o, pwrite_o, paddr_o, pwdata_o}, 0);
    chk("mid_reset_rsp", {rsp_valid_o, rsp_rdata_o, rsp_err_o, timeout_o}, 0);
    @(negedge pclk_i);
    prstn_i = 1'b1;
    last_grant = N - 1;
    @(negedge pclk_i);
    chk("post_reset_rsp", rsp_valid_o, 0);
    do_xfer(4'b1111, 0, 1'b0, $urandom);
    req_valid_i = '0;
    @(negedge pclk_i);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      logic [N-1:0] m;
      randomize_fields();
      m = N'($urandom_range(1, (1 << N) - 1));
      do_xfer(m, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        req_valid_i = '0;
        @(negedge pclk_i);
      end
    end
    req_valid_i = '0;
    @(negedge pclk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
